// File: rtl/wishbone_master.sv
// Wishbone B4 pipelined single-transaction master.
// Accepts one command at a time, runs one bus cycle, and returns a
// one-cycle response pulse carrying read data, error and timeout flags.
// A saturating cycle counter forces termination when a slave never answers.
module wishbone_master #(
    parameter int ADDR_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,

    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_we,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [31:0]           i_cmd_wdata,

    output logic                  o_rsp_valid,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_rsp_timeout,

    output logic                  o_wb_cyc,
    output logic                  o_wb_stb,
    output logic                  o_wb_we,
    output logic [ADDR_WIDTH-1:0] o_wb_addr,
    output logic [31:0]           o_wb_odata,
    output logic [3:0]            o_wb_sel,
    input  logic                  i_wb_ack,
    input  logic                  i_wb_stall,
    input  logic                  i_wb_err,
    input  logic [31:0]           i_wb_idata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RSP  = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t                state_q;
    state_t                state_d;
    logic [15:0]           tmo_cnt_q;
    logic [15:0]           tmo_cnt_d;
    logic [15:0]           tmo_cnt_inc;

    logic                  cmd_ready_d;
    logic                  wb_cyc_d;
    logic                  wb_stb_d;
    logic                  wb_we_d;
    logic [ADDR_WIDTH-1:0] wb_addr_d;
    logic [31:0]           wb_odata_d;
    logic [3:0]            wb_sel_d;
    logic                  rsp_valid_d;
    logic [31:0]           rsp_rdata_d;
    logic                  rsp_err_d;
    logic                  rsp_timeout_d;

    logic                  bus_done;
    logic                  timed_out;

    // The counter sticks at its maximum so a huge TIMEOUT_CYCLES cannot wrap.
    assign tmo_cnt_inc = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;

    // Terminating conditions, only meaningful while the bus cycle is open.
    assign bus_done  = i_wb_ack | i_wb_err;
    assign timed_out = (tmo_cnt_inc >= TIMEOUT_LIMIT);

    // Next-state and next-output computation; every output is a flop fed from here.
    always_comb begin
        state_d       = state_q;
        tmo_cnt_d     = o_wb_cyc ? tmo_cnt_inc : tmo_cnt_q;
        cmd_ready_d   = o_cmd_ready;
        wb_cyc_d      = o_wb_cyc;
        wb_stb_d      = o_wb_stb;
        wb_we_d       = o_wb_we;
        wb_addr_d     = o_wb_addr;
        wb_odata_d    = o_wb_odata;
        rsp_valid_d   = 1'b0;
        rsp_rdata_d   = o_rsp_rdata;
        rsp_err_d     = o_rsp_err;
        rsp_timeout_d = o_rsp_timeout;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                wb_cyc_d    = 1'b0;
                wb_stb_d    = 1'b0;
                if (i_cmd_valid && o_cmd_ready) begin
                    cmd_ready_d   = 1'b0;
                    wb_cyc_d      = 1'b1;
                    wb_stb_d      = 1'b1;
                    wb_we_d       = i_cmd_we;
                    wb_addr_d     = i_cmd_addr;
                    wb_odata_d    = i_cmd_wdata;
                    tmo_cnt_d     = 16'd0;
                    rsp_err_d     = 1'b0;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_REQ;
                end
            end

            ST_REQ, ST_WAIT: begin
                cmd_ready_d = 1'b0;
                if (bus_done) begin
                    // An ack coinciding with stall-low acceptance is a normal completion.
                    wb_cyc_d    = 1'b0;
                    wb_stb_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = i_wb_err;
                    if (!i_wb_err && !o_wb_we) begin
                        rsp_rdata_d = i_wb_idata;
                    end
                    state_d = ST_RSP;
                end else if (timed_out) begin
                    wb_cyc_d      = 1'b0;
                    wb_stb_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RSP;
                end else if ((state_q == ST_REQ) && !i_wb_stall) begin
                    wb_stb_d = 1'b0;
                    state_d  = ST_WAIT;
                end
            end

            ST_RSP: begin
                cmd_ready_d = 1'b1;
                wb_cyc_d    = 1'b0;
                wb_stb_d    = 1'b0;
                state_d     = ST_IDLE;
            end

            default: begin
                cmd_ready_d = 1'b1;
                wb_cyc_d    = 1'b0;
                wb_stb_d    = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        wb_sel_d = wb_cyc_d ? 4'hF : 4'h0;
    end

    // State and output registers; reset aborts any open cycle without a response.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q       <= ST_IDLE;
            tmo_cnt_q     <= 16'd0;
            o_cmd_ready   <= 1'b1;
            o_wb_cyc      <= 1'b0;
            o_wb_stb      <= 1'b0;
            o_wb_we       <= 1'b0;
            o_wb_addr     <= '0;
            o_wb_odata    <= 32'd0;
            o_wb_sel      <= 4'h0;
            o_rsp_valid   <= 1'b0;
            o_rsp_rdata   <= 32'd0;
            o_rsp_err     <= 1'b0;
            o_rsp_timeout <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmo_cnt_q     <= tmo_cnt_d;
            o_cmd_ready   <= cmd_ready_d;
            o_wb_cyc      <= wb_cyc_d;
            o_wb_stb      <= wb_stb_d;
            o_wb_we       <= wb_we_d;
            o_wb_addr     <= wb_addr_d;
            o_wb_odata    <= wb_odata_d;
            o_wb_sel      <= wb_sel_d;
            o_rsp_valid   <= rsp_valid_d;
            o_rsp_rdata   <= rsp_rdata_d;
            o_rsp_err     <= rsp_err_d;
            o_rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule
